// File: rtl/mac_sched_pkg.sv
// Shared types for the MAC layer scheduler: FSM states, the latched job command
// and index-width helpers.
package mac_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CLR,
    COMPUTE,
    DRAIN,
    DONE
  } sched_state_t;

  localparam int CMD_VEC_W = 16;

  typedef struct packed {
    logic                 load_w;
    logic [CMD_VEC_W-1:0] num_vectors;
  } sched_cmd_t;

  // A one-entry range still needs a 1-bit index.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mac_beat_counter.sv
// Beat counter for one stream window: flags the terminal beat (count reached or
// early tlast) and reports both tlast framing faults.
module mac_beat_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] term_val_i,
  input  logic             last_i,
  output logic             term_o,
  output logic             early_last_o,
  output logic             missing_last_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             atTerm;

  assign atTerm         = (cnt_q == term_val_i);
  assign term_o         = en_i & (atTerm | last_i);
  assign early_last_o   = en_i & last_i & ~atTerm;
  assign missing_last_o = en_i & atTerm & ~last_i;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || term_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mac_layer_scheduler.sv
// Job sequencer for the MAC datapath: optional weight load, then clear/compute/drain
// per input vector. Define MAC_SCHED_PERF_EN to add the perf_stall_cycles counter.
module mac_layer_scheduler
  import mac_sched_pkg::*;
#(
  parameter int HIDDEN_UNITS = 64,
  parameter int INPUT_DIM    = 64,
  parameter int VEC_CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_load_w,
  input  logic [VEC_CNT_W-1:0]    cmd_num_vectors,
  input  logic                    in_beat,
  input  logic                    in_last,
  input  logic                    out_beat,
  input  logic                    out_last,
  output logic                    in_allow,
  output logic                    load_w,
  output logic [HIDDEN_UNITS-1:0] load_vector,
  output logic                    clear,
  output logic                    busy,
  output logic                    done,
  output logic                    err
`ifdef MAC_SCHED_PERF_EN
  ,
  output logic [31:0]             perf_stall_cycles
`endif
);

  localparam int BEAT_W = idx_w(INPUT_DIM);
  localparam int UNIT_W = idx_w(HIDDEN_UNITS);
  localparam int CW     = CMD_VEC_W + 1;
  localparam logic [UNIT_W-1:0]       UNIT_LAST = UNIT_W'(HIDDEN_UNITS - 1);
  localparam logic [HIDDEN_UNITS-1:0] UNIT0     = HIDDEN_UNITS'(1);

  sched_state_t         state_q, state_d;
  sched_cmd_t           cmd_q, cmd_d;
  logic [UNIT_W-1:0]    unit_q, unit_d;
  logic [VEC_CNT_W-1:0] vec_q, vec_d;
  logic                 err_q, err_d;

  logic inWindow, inEn, inTerm, inEarly, inMissing;
  logic outEn, outTerm, outEarly, outMissing, drainEnd;
  logic [CW-1:0] vecNext;

  assign inWindow = (state_q == LOAD) || (state_q == COMPUTE);
  assign inEn     = in_beat & inWindow;
  assign outEn    = out_beat & (state_q == DRAIN);
  assign vecNext  = {1'b0, CMD_VEC_W'(vec_q)} + CW'(1);

  mac_beat_counter #(.CNT_W(BEAT_W)) u_in_cnt (
    .clk           (clk),
    .rst           (rst),
    .clr_i         (~inWindow),
    .en_i          (inEn),
    .term_val_i    (BEAT_W'(INPUT_DIM - 1)),
    .last_i        (in_last),
    .term_o        (inTerm),
    .early_last_o  (inEarly),
    .missing_last_o(inMissing)
  );

  mac_beat_counter #(.CNT_W(UNIT_W)) u_out_cnt (
    .clk           (clk),
    .rst           (rst),
    .clr_i         (state_q != DRAIN),
    .en_i          (outEn),
    .term_val_i    (UNIT_LAST),
    .last_i        (out_last),
    .term_o        (outTerm),
    .early_last_o  (outEarly),
    .missing_last_o(outMissing)
  );

  // Output tlast timing is not a framing fault; both flavours simply end the drain.
  assign drainEnd = outTerm | outEarly | outMissing;

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    unit_d  = unit_q;
    vec_d   = vec_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cmd_d.load_w      = cmd_load_w;
          cmd_d.num_vectors = CMD_VEC_W'(cmd_num_vectors);
          err_d             = 1'b0;
          unit_d            = '0;
          vec_d             = '0;
          if (cmd_load_w) begin
            state_d = LOAD;
          end else if (cmd_num_vectors != '0) begin
            state_d = CLR;
          end else begin
            state_d = DONE;
          end
        end
      end
      LOAD: begin
        if (inTerm) begin
          if (unit_q == UNIT_LAST) begin
            unit_d  = '0;
            state_d = (cmd_q.num_vectors != '0) ? CLR : DONE;
          end else begin
            unit_d = unit_q + 1'b1;
          end
        end
      end
      CLR:     state_d = COMPUTE;
      COMPUTE: if (inTerm) state_d = DRAIN;
      DRAIN: begin
        if (drainEnd) begin
          vec_d   = vec_q + 1'b1;
          state_d = (vecNext < {1'b0, cmd_q.num_vectors}) ? CLR : DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (inEarly || inMissing) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      unit_q  <= '0;
      vec_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      unit_q  <= unit_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    cmd_ready   = 1'b0;
    in_allow    = 1'b0;
    load_w      = 1'b0;
    load_vector = '0;
    clear       = 1'b0;
    done        = 1'b0;
    busy        = (state_q != IDLE);
    err         = err_q;
    case (state_q)
      IDLE:    cmd_ready = 1'b1;
      LOAD: begin
        load_w      = 1'b1;
        in_allow    = 1'b1;
        load_vector = UNIT0 << unit_q;
      end
      CLR:     clear    = 1'b1;
      COMPUTE: in_allow = 1'b1;
      DONE:    done     = 1'b1;
      default: ;
    endcase
  end

`ifdef MAC_SCHED_PERF_EN
  logic [31:0] perf_q, perf_d;
  logic        stallCycle;

  assign stallCycle = (inWindow && !in_beat) || ((state_q == DRAIN) && !out_beat);

  always_comb begin
    perf_d = perf_q;
    if ((state_q == IDLE) && cmd_valid) begin
      perf_d = '0;
    end else if (stallCycle && (perf_q != 32'hFFFF_FFFF)) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_stall_cycles = perf_q;
`endif

endmodule

// File: tb/tb_mac_layer_scheduler.sv
// Directed bench for mac_layer_scheduler: a job table driven through a loop plus
// hand sequences for early tlast, empty jobs, mid-load reset and (MAC_SCHED_PERF_EN) stalls.
module tb_mac_layer_scheduler;

  localparam int HU = 64;
  localparam int ID = 64;
  localparam int VW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_load_w = 1'b0;
  logic [VW-1:0] cmd_num_vectors = '0;
  logic          in_beat = 1'b0;
  logic          in_last = 1'b0;
  logic          out_beat = 1'b0;
  logic          out_last = 1'b0;
  logic          in_allow;
  logic          load_w;
  logic [HU-1:0] load_vector;
  logic          clear;
  logic          busy;
  logic          done;
  logic          err;
`ifdef MAC_SCHED_PERF_EN
  logic [31:0]   perf_stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  mac_layer_scheduler #(
    .HIDDEN_UNITS(HU),
    .INPUT_DIM   (ID),
    .VEC_CNT_W   (VW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_load_w     (cmd_load_w),
    .cmd_num_vectors(cmd_num_vectors),
    .in_beat        (in_beat),
    .in_last        (in_last),
    .out_beat       (out_beat),
    .out_last       (out_last),
    .in_allow       (in_allow),
    .load_w         (load_w),
    .load_vector    (load_vector),
    .clear          (clear),
    .busy           (busy),
    .done           (done),
    .err            (err)
`ifdef MAC_SCHED_PERF_EN
    ,
    .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Event monitor, sampled on the falling edge. A "segment" runs from one clear to the
  // next clear or done; a good segment has ID input beats and an out_last.
  int monClears = 0, monDones = 0, monInBeats = 0, monAllow = 0, monSeqBad = 0;
  int monSeg = 0;
  bit monSegOut = 0, monActive = 0;

  always @(negedge clk) begin
    if (clear) begin
      if (monActive && (monSeg != ID || !monSegOut)) monSeqBad++;
      monActive = 1;
      monSeg    = 0;
      monSegOut = 0;
      monClears++;
    end
    if (in_allow) monAllow++;
    if (in_beat && in_allow) begin
      monInBeats++;
      monSeg++;
    end
    if (out_beat && out_last) monSegOut = 1;
    if (done) begin
      monDones++;
      if (monActive && (monSeg != ID || !monSegOut)) monSeqBad++;
      monActive = 0;
    end
  end

  typedef struct {
    bit loadW;
    int nv;
    int lastAt;     // in_last index for the first vector; >= ID means never sent
    bit drainLast;
    int expClears;
    int expDones;
    int expInBeats;
    int expSeqBad;
    bit expErr;
  } job_t;

  job_t jobs[6];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit cond(input int which);
    case (which)
      0:       return in_allow;
      1:       return clear;
      default: return done;
    endcase
  endfunction

  task automatic waitUntil(input int which, input string name);
    int n = 0;
    while (!cond(which) && n < 2000) begin
      tick();
      n++;
    end
    if (!cond(which)) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: timeout after %0d cycles, expected 1", name, n);
    end
  endtask

  task automatic acceptCmd(input bit lw, input int nv, input string name);
    checkOutput({name, ".cmd_ready"}, 64'(cmd_ready), 64'd1);
    cmd_valid       = 1'b1;
    cmd_load_w      = lw;
    cmd_num_vectors = nv[VW-1:0];
    tick();
    cmd_valid       = 1'b0;
    cmd_load_w      = 1'b0;
    cmd_num_vectors = '0;
  endtask

  task automatic driveIn(input int nBeats, input int lastIdx);
    for (int b = 0; b < nBeats; b++) begin
      waitUntil(0, "in_allow");
      in_beat = 1'b1;
      in_last = (b == lastIdx);
      tick();
    end
    in_beat = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic driveOut(input bit withLast);
    for (int k = 0; k < HU; k++) begin
      out_beat = 1'b1;
      out_last = withLast && (k == HU - 1);
      tick();
    end
    out_beat = 1'b0;
    out_last = 1'b0;
  endtask

  task automatic applyStimulus(input job_t j, input int idx);
    int c0 = monClears, d0 = monDones, b0 = monInBeats, s0 = monSeqBad;
    int loadBad = 0;
    string nm = $sformatf("job%0d", idx);
    acceptCmd(j.loadW, j.nv, nm);
    if (j.loadW) begin
      for (int u = 0; u < HU; u++) begin
        for (int b = 0; b < ID; b++) begin
          waitUntil(0, {nm, ".load_allow"});
          if (b == 0 && load_vector !== (64'd1 << u)) loadBad++;
          in_beat = 1'b1;
          in_last = (b == ID - 1);
          tick();
        end
      end
      in_beat = 1'b0;
      in_last = 1'b0;
      checkOutput({nm, ".load_vector_walk_bad"}, 64'(loadBad), 64'd0);
    end
    for (int v = 0; v < j.nv; v++) begin
      waitUntil(1, {nm, ".clear"});
      tick();
      if (v == 0) driveIn((j.lastAt < ID) ? j.lastAt + 1 : ID, j.lastAt);
      else        driveIn(ID, ID - 1);
      driveOut(j.drainLast);
    end
    waitUntil(2, {nm, ".done"});
    checkOutput({nm, ".err"}, 64'(err), 64'(j.expErr));
    tick();
    checkOutput({nm, ".busy_after_done"}, 64'(busy), 64'd0);
    checkOutput({nm, ".clears"}, 64'(monClears - c0), 64'(j.expClears));
    checkOutput({nm, ".dones"}, 64'(monDones - d0), 64'(j.expDones));
    checkOutput({nm, ".in_beats"}, 64'(monInBeats - b0), 64'(j.expInBeats));
    checkOutput({nm, ".seq_bad"}, 64'(monSeqBad - s0), 64'(j.expSeqBad));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout: simulation still running, expected to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int a0;
    //                loadW nv lastAt drainLast clears dones inBeats seqBad err
    jobs[0] = '{1, 1, 63, 1, 1, 1, 4160, 0, 0};
    jobs[1] = '{0, 3, 63, 1, 3, 1, 192,  0, 0};
    jobs[2] = '{0, 2, 10, 1, 2, 1, 75,   1, 1};
    jobs[3] = '{1, 0, 63, 1, 0, 1, 4096, 0, 0};
    jobs[4] = '{0, 1, 99, 1, 1, 1, 64,   0, 1};
    jobs[5] = '{0, 2, 63, 0, 2, 1, 128,  2, 0};

    // Reset state
    tick();
    tick();
    checkOutput("rst.cmd_ready", 64'(cmd_ready), 64'd1);
    checkOutput("rst.busy", 64'(busy), 64'd0);
    checkOutput("rst.load_w", 64'(load_w), 64'd0);
    checkOutput("rst.in_allow", 64'(in_allow), 64'd0);
    checkOutput("rst.clear", 64'(clear), 64'd0);
    checkOutput("rst.done", 64'(done), 64'd0);
    checkOutput("rst.err", 64'(err), 64'd0);
    checkOutput("rst.load_vector", load_vector, 64'd0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) applyStimulus(jobs[i], i);

    // Early tlast on beat 10: DRAIN next cycle, err sticky until the next accept
    acceptCmd(0, 1, "early");
    waitUntil(1, "early.clear");
    tick();
    for (int b = 0; b <= 10; b++) begin
      in_beat = 1'b1;
      in_last = (b == 10);
      tick();
    end
    in_beat = 1'b0;
    in_last = 1'b0;
    checkOutput("early.err", 64'(err), 64'd1);
    checkOutput("early.in_allow_drain", 64'(in_allow), 64'd0);
    checkOutput("early.busy_drain", 64'(busy), 64'd1);
    checkOutput("early.clear_drain", 64'(clear), 64'd0);
    driveOut(1);
    waitUntil(2, "early.done");
    checkOutput("early.err_at_done", 64'(err), 64'd1);
    tick();
    checkOutput("early.err_idle", 64'(err), 64'd1);

    // Empty job: done right after accept, no clear, no input window
    a0 = monAllow;
    acceptCmd(0, 0, "nv0");
    checkOutput("nv0.err_cleared", 64'(err), 64'd0);
    checkOutput("nv0.done", 64'(done), 64'd1);
    checkOutput("nv0.clear", 64'(clear), 64'd0);
    checkOutput("nv0.busy", 64'(busy), 64'd1);
    tick();
    checkOutput("nv0.done_pulse", 64'(done), 64'd0);
    checkOutput("nv0.busy_end", 64'(busy), 64'd0);
    checkOutput("nv0.in_allow_cycles", 64'(monAllow - a0), 64'd0);

    // Reset mid-LOAD at unit 5, then a fresh load restarts at unit 0
    acceptCmd(1, 1, "rstload");
    for (int i = 0; i < 5 * ID + 3; i++) begin
      in_beat = 1'b1;
      in_last = ((i % ID) == ID - 1);
      tick();
    end
    in_beat = 1'b0;
    in_last = 1'b0;
    checkOutput("rstload.unit5", load_vector, 64'd1 << 5);
    rst = 1'b0;
    #1;
    checkOutput("rstload.cmd_ready", 64'(cmd_ready), 64'd1);
    checkOutput("rstload.load_w", 64'(load_w), 64'd0);
    checkOutput("rstload.load_vector", load_vector, 64'd0);
    checkOutput("rstload.busy", 64'(busy), 64'd0);
    checkOutput("rstload.in_allow", 64'(in_allow), 64'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    acceptCmd(1, 1, "reload");
    checkOutput("reload.load_w", 64'(load_w), 64'd1);
    checkOutput("reload.load_vector", load_vector, 64'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();

`ifdef MAC_SCHED_PERF_EN
    // Seven idle COMPUTE cycles, everything else streams without gaps
    acceptCmd(0, 1, "perf");
    waitUntil(1, "perf.clear");
    tick();
    repeat (7) tick();
    driveIn(ID, ID - 1);
    driveOut(1);
    waitUntil(2, "perf.done");
    checkOutput("perf.stall_cycles", 64'(perf_stall_cycles), 64'd7);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
